// File: rtl/mips_alu_decode.sv
// Single-cycle MIPS decode and ALU with every output registered once.
// Decode and the ALU are purely combinational; one register stage sits in front of all outputs.
module mips_alu_decode (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] inst,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        reg_dst,
    output logic [1:0]  alu_src,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  branch,
    output logic [1:0]  jump,
    output logic        jr,
    output logic        do_extend,
    output logic        halted
);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI
    } alu_op_e;

    typedef struct packed {
        logic       reg_dst;
        logic [1:0] alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] branch;
        logic [1:0] jump;
        logic       jr;
        logic       do_extend;
        logic       halted;
    } ctrl_t;

    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic        unused_reg_fields;

    assign opcode = inst[31:26];
    assign shamt  = inst[10:6];
    assign func   = inst[5:0];
    assign imm    = inst[15:0];
    // rs/rt/rd register numbers are consumed by the register file, not here.
    assign unused_reg_fields = ^inst[25:16];

    ctrl_t   ctrl_d, ctrl_q;
    alu_op_e op;
    logic    r_write;

    always_comb begin
        ctrl_d  = '0;
        op      = OP_ADD;
        r_write = 1'b0;
        case (opcode)
            6'h00: begin
                case (func)
                    6'h20, 6'h21: r_write = 1'b1;
                    6'h22, 6'h23: begin op = OP_SUB;  r_write = 1'b1; end
                    6'h24:        begin op = OP_AND;  r_write = 1'b1; end
                    6'h25:        begin op = OP_OR;   r_write = 1'b1; end
                    6'h26:        begin op = OP_XOR;  r_write = 1'b1; end
                    6'h27:        begin op = OP_NOR;  r_write = 1'b1; end
                    6'h2A:        begin op = OP_SLT;  r_write = 1'b1; end
                    6'h2B:        begin op = OP_SLTU; r_write = 1'b1; end
                    6'h00: begin op = OP_SLL; r_write = 1'b1; ctrl_d.alu_src = 2'b01; end
                    6'h02: begin op = OP_SRL; r_write = 1'b1; ctrl_d.alu_src = 2'b01; end
                    6'h03: begin op = OP_SRA; r_write = 1'b1; ctrl_d.alu_src = 2'b01; end
                    6'h04:        begin op = OP_SLL;  r_write = 1'b1; end
                    6'h06:        begin op = OP_SRL;  r_write = 1'b1; end
                    6'h07:        begin op = OP_SRA;  r_write = 1'b1; end
                    6'h08:        ctrl_d.jr     = 1'b1;
                    6'h0C:        ctrl_d.halted = 1'b1;
                    default:      ;
                endcase
                ctrl_d.reg_dst   = r_write;
                ctrl_d.reg_write = r_write;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                ctrl_d.alu_src   = 2'b10;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.do_extend = 1'b1;
                op = (opcode == 6'h0A) ? OP_SLT : (opcode == 6'h0B) ? OP_SLTU : OP_ADD;
            end
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                ctrl_d.alu_src   = 2'b10;
                ctrl_d.reg_write = 1'b1;
                op = (opcode == 6'h0C) ? OP_AND : (opcode == 6'h0D) ? OP_OR :
                     (opcode == 6'h0E) ? OP_XOR : OP_LUI;
            end
            6'h23, 6'h20: begin
                ctrl_d.alu_src    = 2'b10;
                ctrl_d.do_extend  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
            end
            6'h2B, 6'h28: begin
                ctrl_d.alu_src   = 2'b10;
                ctrl_d.do_extend = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07, 6'h01: begin
                op = OP_SUB;
                ctrl_d.do_extend = 1'b1;
                case (opcode)
                    6'h04:   ctrl_d.branch = 3'b100;
                    6'h05:   ctrl_d.branch = 3'b101;
                    6'h06:   ctrl_d.branch = 3'b110;
                    6'h07:   ctrl_d.branch = 3'b111;
                    default: ctrl_d.branch = 3'b001;
                endcase
            end
            6'h02: ctrl_d.jump = 2'b01;
            6'h03: begin
                ctrl_d.jump      = 2'b10;
                ctrl_d.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    logic [31:0] imm_ext, op_a, op_b, result_d, alu_result_q;
    logic        zero_q;

    assign imm_ext = ctrl_d.do_extend ? {{16{imm[15]}}, imm} : {16'b0, imm};
    assign op_a    = ctrl_d.alu_src[0] ? {27'b0, shamt} : rs_data;
    assign op_b    = ctrl_d.alu_src[1] ? imm_ext : rt_data;

    // Shifts move operand B by A[4:0]; A carries shamt or rs depending on the variant.
    always_comb begin
        result_d = op_a + op_b;
        case (op)
            OP_SUB:  result_d = op_a - op_b;
            OP_AND:  result_d = op_a & op_b;
            OP_OR:   result_d = op_a | op_b;
            OP_XOR:  result_d = op_a ^ op_b;
            OP_NOR:  result_d = ~(op_a | op_b);
            OP_SLT:  result_d = {31'b0, $signed(op_a) < $signed(op_b)};
            OP_SLTU: result_d = {31'b0, op_a < op_b};
            OP_SLL:  result_d = op_b << op_a[4:0];
            OP_SRL:  result_d = op_b >> op_a[4:0];
            OP_SRA:  result_d = $unsigned($signed(op_b) >>> op_a[4:0]);
            OP_LUI:  result_d = {imm, 16'b0};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ctrl_q       <= '0;
            alu_result_q <= '0;
            zero_q       <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            alu_result_q <= result_d;
            zero_q       <= (result_d == 32'd0);
        end
    end

    assign alu_result = alu_result_q;
    assign zero       = zero_q;
    assign reg_dst    = ctrl_q.reg_dst;
    assign alu_src    = ctrl_q.alu_src;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign jr         = ctrl_q.jr;
    assign do_extend  = ctrl_q.do_extend;
    assign halted     = ctrl_q.halted;

endmodule

// File: tb/tb_mips_alu_decode.sv
// Bench for mips_alu_decode: directed cases, randomized instructions against an
// instruction-level reference model, latency, and asynchronous reset behaviour.
module tb_mips_alu_decode;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic [31:0] inst = '0, rs_data = '0, rt_data = '0;
    logic [31:0] alu_result;
    logic        zero, reg_dst, mem_to_reg, reg_write, mem_read, mem_write;
    logic        jr, do_extend, halted;
    logic [1:0]  alu_src, jump;
    logic [2:0]  branch;

    int n_tests = 0;
    int n_fail  = 0;
    logic [47:0] exp_q[$];

    always #5 clk = ~clk;

    mips_alu_decode dut (
        .clk(clk), .rst_b(rst_b), .inst(inst), .rs_data(rs_data), .rt_data(rt_data),
        .alu_result(alu_result), .zero(zero), .reg_dst(reg_dst), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .jump(jump), .jr(jr),
        .do_extend(do_extend), .halted(halted)
    );

    logic [47:0] dut_vec;
    assign dut_vec = {alu_result, zero, reg_dst, alu_src, mem_to_reg, reg_write,
                      mem_read, mem_write, branch, jump, jr, do_extend, halted};

    // Reference: what one instruction does, described per mnemonic.
    function automatic logic [47:0] model(input logic [31:0] ins, input logic [31:0] rs,
                                          input logic [31:0] rt);
        int unsigned opc, fn;
        logic [15:0] imm;
        logic [31:0] a, b, res;
        logic [1:0]  asrc, jp;
        logic [2:0]  br;
        logic        rd, m2r, rw, mr, mw, jrr, ext, hlt;
        string       op;
        opc = ins[31:26]; fn = ins[5:0]; imm = ins[15:0];
        {rd, m2r, rw, mr, mw, jrr, ext, hlt} = '0;
        asrc = 0; jp = 0; br = 0; op = "add";
        if (opc == 0) begin
            if (fn inside {'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B,
                           0, 2, 3, 4, 6, 7}) begin
                rd = 1; rw = 1;
            end
            case (fn)
                'h22, 'h23: op = "sub";
                'h24: op = "and";
                'h25: op = "or";
                'h26: op = "xor";
                'h27: op = "nor";
                'h2A: op = "slt";
                'h2B: op = "sltu";
                0: begin op = "sll"; asrc = 1; end
                2: begin op = "srl"; asrc = 1; end
                3: begin op = "sra"; asrc = 1; end
                4: op = "sll";
                6: op = "srl";
                7: op = "sra";
                8: jrr = 1;
                'h0C: hlt = 1;
                default: ;
            endcase
        end else begin
            case (opc)
                8, 9:  begin asrc = 2; rw = 1; ext = 1; end
                'h0A:  begin asrc = 2; rw = 1; ext = 1; op = "slt"; end
                'h0B:  begin asrc = 2; rw = 1; ext = 1; op = "sltu"; end
                'h0C:  begin asrc = 2; rw = 1; op = "and"; end
                'h0D:  begin asrc = 2; rw = 1; op = "or"; end
                'h0E:  begin asrc = 2; rw = 1; op = "xor"; end
                'h0F:  begin asrc = 2; rw = 1; op = "lui"; end
                'h23, 'h20: begin asrc = 2; ext = 1; mr = 1; m2r = 1; rw = 1; end
                'h2B, 'h28: begin asrc = 2; ext = 1; mw = 1; end
                4: begin op = "sub"; ext = 1; br = 3'b100; end
                5: begin op = "sub"; ext = 1; br = 3'b101; end
                6: begin op = "sub"; ext = 1; br = 3'b110; end
                7: begin op = "sub"; ext = 1; br = 3'b111; end
                1: begin op = "sub"; ext = 1; br = 3'b001; end
                2: jp = 2'b01;
                3: begin jp = 2'b10; rw = 1; end
                default: ;
            endcase
        end
        a = asrc[0] ? 32'(ins[10:6]) : rs;
        b = asrc[1] ? (ext ? 32'(longint'($signed(imm))) : 32'(imm)) : rt;
        case (op)
            "add":  res = 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            "sub":  res = 32'((longint'(a) + 64'h1_0000_0000 - longint'(b)) % 64'h1_0000_0000);
            "and":  res = a & b;
            "or":   res = a | b;
            "xor":  res = a ^ b;
            "nor":  res = ~(a | b);
            "slt":  res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            "sltu": res = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            "sll":  res = 32'(longint'(b) * (64'd1 << a[4:0]));
            "srl":  res = 32'(longint'(b) / (64'd1 << a[4:0]));
            "sra":  res = (b >> a[4:0]) | (b[31] ? ~(32'hFFFF_FFFF >> a[4:0]) : 32'd0);
            default: res = imm * 32'h1_0000;
        endcase
        return {res, res == 0, rd, asrc, m2r, rw, mr, mw, br, jp, jrr, ext, hlt};
    endfunction

    // Driver: present one instruction mid-cycle, wait for the capturing edge.
    task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        inst = ins; rs_data = rs; rt_data = rt;
        exp_q.push_back(model(ins, rs, rt));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst_b = 1'b0;
        #1;
        n_tests++;
        if (dut_vec !== 48'd0) begin
            n_fail++; $display("FAIL reset_clear got=%h want=0", dut_vec);
        end
        @(posedge clk); #1;
        n_tests++;
        if (dut_vec !== 48'd0) begin
            n_fail++; $display("FAIL reset_hold got=%h want=0", dut_vec);
        end
        @(negedge clk) rst_b = 1'b1;
    endtask

    task automatic test_directed;
        logic [47:0] e;
        drive({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7);
        e = exp_q.pop_front(); n_tests++;
        if (alu_result !== 32'd12 || zero !== 1'b0 || reg_dst !== 1'b1 || reg_write !== 1'b1) begin
            n_fail++; $display("FAIL add_5_7 got=%h res=%h", dut_vec, alu_result);
        end
        n_tests++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL add_model got=%h want=%h", dut_vec, e); end

        drive({6'h04, 5'd1, 5'd2, 16'h0010}, 32'h1234, 32'h1234);
        e = exp_q.pop_front(); n_tests++;
        if (alu_result !== 32'd0 || zero !== 1'b1 || branch !== 3'b100 || reg_write !== 1'b0) begin
            n_fail++; $display("FAIL beq_equal got=%h want res=0 zero=1 br=100", dut_vec);
        end
        n_tests++;
        if (dut_vec !== e) begin n_fail++; $display("FAIL beq_model got=%h want=%h", dut_vec, e); end

        drive({6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h03}, 32'h0, 32'h8000_0000);
        void'(exp_q.pop_front()); n_tests++;
        if (alu_result !== 32'hF800_0000) begin
            n_fail++; $display("FAIL sra_4 got=%h want=f8000000", alu_result);
        end
        drive({6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h02}, 32'h0, 32'h8000_0000);
        void'(exp_q.pop_front()); n_tests++;
        if (alu_result !== 32'h0800_0000) begin
            n_fail++; $display("FAIL srl_4 got=%h want=08000000", alu_result);
        end

        drive({6'h0D, 5'd0, 5'd2, 16'h8001}, 32'h0, 32'hDEAD_BEEF);
        void'(exp_q.pop_front()); n_tests++;
        if (alu_result !== 32'h0000_8001 || do_extend !== 1'b0 || alu_src !== 2'b10) begin
            n_fail++; $display("FAIL ori_8001 got=%h res=%h", dut_vec, alu_result);
        end
        drive({6'h08, 5'd0, 5'd2, 16'h8001}, 32'h0, 32'hDEAD_BEEF);
        void'(exp_q.pop_front()); n_tests++;
        if (alu_result !== 32'hFFFF_8001 || do_extend !== 1'b1) begin
            n_fail++; $display("FAIL addi_8001 got=%h res=%h", dut_vec, alu_result);
        end
        drive({6'h0F, 5'd0, 5'd2, 16'hABCD}, 32'h1111_1111, 32'h0);
        void'(exp_q.pop_front()); n_tests++;
        if (alu_result !== 32'hABCD_0000) begin
            n_fail++; $display("FAIL lui_abcd got=%h want=abcd0000", alu_result);
        end

        drive({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2A}, 32'hFFFF_FFFF, 32'd1);
        void'(exp_q.pop_front()); n_tests++;
        if (alu_result !== 32'd1) begin n_fail++; $display("FAIL slt_neg got=%h want=1", alu_result); end
        drive({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2B}, 32'hFFFF_FFFF, 32'd1);
        void'(exp_q.pop_front()); n_tests++;
        if (alu_result !== 32'd0 || zero !== 1'b1) begin
            n_fail++; $display("FAIL sltu_neg got=%h want=0", alu_result);
        end

        drive({6'h2B, 5'd1, 5'd2, 16'hFFFC}, 32'd100, 32'd9);
        void'(exp_q.pop_front()); n_tests++;
        if (alu_result !== 32'd96 || mem_write !== 1'b1 || reg_write !== 1'b0) begin
            n_fail++; $display("FAIL sw_addr got=%h res=%h", dut_vec, alu_result);
        end
        drive({6'h3F, 26'h3FF_FFFF}, 32'hFFFF_FFFF, 32'd2);
        void'(exp_q.pop_front()); n_tests++;
        if (alu_result !== 32'd1 || dut_vec[15:0] !== 16'd0) begin
            n_fail++; $display("FAIL unlisted_op got=%h want res=1 ctrl=0", dut_vec);
        end
    endtask

    task automatic test_random;
        int unsigned i_ops[19] = '{8, 9, 10, 11, 12, 13, 14, 15, 'h23, 'h20, 'h2B, 'h28,
                                   4, 5, 6, 7, 1, 2, 3};
        int unsigned r_fns[18] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A,
                                   'h2B, 0, 2, 3, 4, 6, 7, 8, 'h0C};
        logic [31:0] edges[6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                                  32'hFFFF_FFFF, 32'h1F};
        logic [31:0] ins, rs, rt;
        logic [47:0] e;
        int unsigned sel;
        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                ins[31:26] = 6'd0;
                ins[5:0] = 6'(r_fns[$urandom_range(0, 17)]);
            end else if (sel < 8) begin
                ins[31:26] = 6'(i_ops[$urandom_range(0, 18)]);
            end
            rs = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            rt = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 7) == 0) rt = rs;
            drive(ins, rs, rt);
            e = exp_q.pop_front();
            n_tests++;
            if (dut_vec !== e) begin
                n_fail++;
                $display("FAIL random[%0d] inst=%h rs=%h rt=%h got=%h want=%h",
                         i, ins, rs, rt, dut_vec, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] prev, e;
        drive({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 32'd10, 32'd3);
        prev = exp_q.pop_front();
        @(negedge clk);
        inst = {6'h0E, 5'd1, 5'd2, 16'h00FF}; rs_data = 32'h0F0F_0F0F;
        exp_q.push_back(model(inst, rs_data, rt_data));
        #1; n_tests++;
        if (dut_vec !== prev) begin
            n_fail++; $display("FAIL hold_until_edge got=%h want=%h", dut_vec, prev);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_tests++;
        if (dut_vec !== e || alu_result !== 32'h0F0F_0FF0) begin
            n_fail++; $display("FAIL next_edge_xori got=%h want=%h", dut_vec, e);
        end
    endtask

    task automatic test_reset_midstream;
        logic [47:0] e;
        drive({6'h00, 20'd0, 6'h0C}, 32'd1, 32'd2);
        void'(exp_q.pop_front()); n_tests++;
        if (halted !== 1'b1 || reg_write !== 1'b0) begin
            n_fail++; $display("FAIL syscall_halt got halted=%b rw=%b", halted, reg_write);
        end
        #2 rst_b = 1'b0;
        #1; n_tests++;
        if (dut_vec !== 48'd0) begin
            n_fail++; $display("FAIL async_reset got=%h want=0", dut_vec);
        end
        @(negedge clk);
        inst = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}; rs_data = 32'd5; rt_data = 32'd7;
        rst_b = 1'b1;
        e = model(inst, rs_data, rt_data);
        @(posedge clk); #1;
        n_tests++;
        if (dut_vec !== e) begin
            n_fail++; $display("FAIL first_after_reset got=%h want=%h", dut_vec, e);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_alu_decode.md
MIPS_ALU_DECODE -- requirements
Module: mips_alu_decode

Interface
REQ-001 clk  input  1  sole clock; all outputs update on its rising edge.
REQ-002 rst_b  input  1  asynchronous, active-low reset.
REQ-003 inst  input  32  instruction word; opcode=inst[31:26], shamt=inst[10:6], func=inst[5:0], imm=inst[15:0].
REQ-004 rs_data  input  32  register rs value.
REQ-005 rt_data  input  32  register rt value.
REQ-006 alu_result  output  32  registered ALU result.
REQ-007 zero  output  1  registered (ALU result == 0).
REQ-008 reg_dst  output  1  1 = write rd (inst[15:11]); 0 = write rt.
REQ-009 alu_src  output  2  bit0: A = zero-extended shamt; bit1: B = extended immediate.
REQ-010 mem_to_reg, reg_write, mem_read, mem_write  output  1 each  standard MIPS datapath controls.
REQ-011 branch  output  3  100 beq, 101 bne, 110 blez, 111 bgtz, 001 bgez, 000 none.
REQ-012 jump  output  2  01 j, 10 jal, 00 none.
REQ-013 jr, do_extend, halted  output  1 each  jump-register; sign-extend immediate (0 = zero-extend); syscall halt.

Function
REQ-014 Decode and ALU SHALL be combinational from inst/rs_data/rt_data; every output SHALL be registered, with latency exactly 1 clk.
REQ-015 Operand A SHALL be {27'b0,shamt} if alu_src[0], else rs_data; operand B SHALL be ext(imm) if alu_src[1], else rt_data.
REQ-016 ext(imm) SHALL be {16{imm[15]},imm} when do_extend=1, else {16'b0,imm}.
REQ-017 R-type (opcode 0), reg_dst=1, reg_write=1: add 0x20/addu 0x21 ADD; sub 0x22/subu 0x23 SUB; and 0x24; or 0x25; xor 0x26; nor 0x27; slt 0x2A; sltu 0x2B.
REQ-018 Shifts, reg_dst=1, reg_write=1: sll 0x00, srl 0x02, sra 0x03 with alu_src=01; sllv 0x04, srlv 0x06, srav 0x07 with alu_src=00; result = B shifted by A[4:0].
REQ-019 jr (func 0x08): jr=1, reg_write=0; syscall (func 0x0C): halted=1, reg_write=0.
REQ-020 I-type ALU, alu_src=10, reg_write=1: addi 0x08, addiu 0x09 ADD, slti 0x0A, sltiu 0x0B, all do_extend=1; andi 0x0C, ori 0x0D, xori 0x0E with do_extend=0; lui 0x0F: result = {imm,16'b0}.
REQ-021 Memory ops, ADD, alu_src=10, do_extend=1: lw 0x23 and lb 0x20 with mem_read=1, mem_to_reg=1, reg_write=1; sw 0x2B and sb 0x28 with mem_write=1.
REQ-022 Branches, SUB, alu_src=00, do_extend=1: beq 0x04, bne 0x05, blez 0x06, bgtz 0x07, bgez 0x01, coded per REQ-011.
REQ-023 j 0x02: jump=01; jal 0x03: jump=10, reg_write=1.
REQ-024 Arithmetic SHALL wrap modulo 2^32 with no overflow trap; slt/slti SHALL compare signed, sltu/sltiu unsigned, producing 32'd1 or 32'd0.
REQ-025 sra/srav SHALL replicate B[31]; srl/srlv SHALL fill with zeros.
REQ-026 Unlisted opcode/func SHALL drive every control low, perform ADD of A and B, and register the result.

Reset
REQ-027 rst_b=0 SHALL immediately clear all outputs to 0, including zero, independent of clk.
REQ-028 The first rising clk after rst_b deasserts SHALL register the current inst; reset asserted mid-stream SHALL discard in-flight values.

Verification
REQ-029 add: rs=5, rt=7 -> next edge alu_result=12, zero=0, reg_dst=1, reg_write=1.
REQ-030 beq: rs=rt=0x1234 -> alu_result=0, zero=1, branch=100, reg_write=0.
REQ-031 sra shamt=4, rt=0x80000000 -> 0xF8000000; srl gives 0x08000000.
REQ-032 ori imm=0x8001, rs=0 -> 0x00008001; addi same imm -> 0xFFFF8001; lui imm=0xABCD -> 0xABCD0000.
REQ-033 slt rs=-1, rt=1 -> 1; sltu same operands -> 0.
REQ-034 syscall -> halted=1 next edge; assert rst_b=0 between edges -> all outputs 0 at once.
